// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone B3 classic GPIO slave with per-pin direction,
// synchronised and debounced inputs, edge capture into a W1C pending
// register, and one level interrupt.
module wb_gpio_irq #(
    parameter int GPIO_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_WIDTH = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_dir_o,
    output logic                  irq_o
);
    localparam int W  = GPIO_WIDTH;
    localparam int DW = DEBOUNCE_WIDTH;

    typedef enum logic [2:0] {
        REG_IN, REG_OUT, REG_DIR, REG_IRQ_EN,
        REG_RISE, REG_FALL, REG_PENDING, REG_DEBOUNCE
    } reg_e;

    function automatic logic [31:0] zext_w(input logic [W-1:0] v);
        logic [31:0] r;
        r        = '0;
        r[W-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] zext_d(input logic [DW-1:0] v);
        logic [31:0] r;
        r         = '0;
        r[DW-1:0] = v;
        return r;
    endfunction

    logic                       ack_q, ack_d;
    logic [31:0]                dat_q, dat_d;
    logic [W-1:0]               out_q, out_d, dir_q, dir_d, ien_q, ien_d;
    logic [W-1:0]               rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
    logic [DW-1:0]              dbn_q, dbn_d, cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]               sample_q, sample_d, deb_q, deb_d, prev_q, prev_d;

    logic        req, wr, rd, tick;
    reg_e        wsel;
    logic [31:0] bmask, rdata;
    logic [W-1:0]  mask_w, dat_w, sync_w, match, rise_ev, fall_ev, clr;
    logic [DW-1:0] mask_d, dat_dw;
    logic        unused_bits;

    // Bus decode: one request per ack, byte-lane write mask
    always_comb begin
        req    = wb_cyc_i & wb_stb_i & ~ack_q;
        wr     = req & wb_we_i;
        rd     = req & ~wb_we_i;
        wsel   = reg_e'(wb_adr_i[4:2]);
        bmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        mask_w = bmask[W-1:0];
        dat_w  = wb_dat_i[W-1:0];
        mask_d = bmask[DW-1:0];
        dat_dw = wb_dat_i[DW-1:0];
    end

    // Address bits outside [4:2] and data above the register widths are don't-care
    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, bmask};

    // Register file writes (byte-merged), read mux and ack/data return
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        rise_d = rise_q;
        fall_d = fall_q;
        dbn_d  = dbn_q;
        if (wr) begin
            case (wsel)
                REG_OUT:      out_d  = (out_q  & ~mask_w) | (dat_w & mask_w);
                REG_DIR:      dir_d  = (dir_q  & ~mask_w) | (dat_w & mask_w);
                REG_IRQ_EN:   ien_d  = (ien_q  & ~mask_w) | (dat_w & mask_w);
                REG_RISE:     rise_d = (rise_q & ~mask_w) | (dat_w & mask_w);
                REG_FALL:     fall_d = (fall_q & ~mask_w) | (dat_w & mask_w);
                REG_DEBOUNCE: dbn_d  = (dbn_q  & ~mask_d) | (dat_dw & mask_d);
                default: ;
            endcase
        end
        rdata = '0;
        case (wsel)
            REG_IN:       rdata = zext_w(deb_q);
            REG_OUT:      rdata = zext_w(out_q);
            REG_DIR:      rdata = zext_w(dir_q);
            REG_IRQ_EN:   rdata = zext_w(ien_q);
            REG_RISE:     rdata = zext_w(rise_q);
            REG_FALL:     rdata = zext_w(fall_q);
            REG_PENDING:  rdata = zext_w(pend_q);
            REG_DEBOUNCE: rdata = zext_d(dbn_q);
            default: ;
        endcase
        ack_d = req;
        dat_d = rd ? rdata : dat_q;
    end

    // Input path: synchroniser, prescaler, per-pin two-tick debounce
    always_comb begin
        sync_d    = '0;
        sync_d[0] = gpio_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        sync_w   = sync_q[SYNC_STAGES-1];
        tick     = (cnt_q == dbn_q);
        cnt_d    = tick ? '0 : cnt_q + DW'(1);
        if (wr && wsel == REG_DEBOUNCE) cnt_d = '0;
        match    = ~(sync_w ^ sample_q);
        sample_d = sample_q;
        deb_d    = deb_q;
        if (dbn_q == '0) begin
            sample_d = sync_w;
            deb_d    = sync_w;
        end else if (tick) begin
            sample_d = sync_w;
            // only pins that held the same level across both ticks move
            deb_d    = (deb_q & ~match) | (sync_w & match);
        end
    end

    // Edge capture; a new edge beats a same-cycle W1C of that bit
    always_comb begin
        rise_ev = deb_q & ~prev_q;
        fall_ev = ~deb_q & prev_q;
        clr     = (wr && wsel == REG_PENDING) ? (dat_w & mask_w) : '0;
        pend_d  = (pend_q & ~clr) | (rise_ev & rise_q) | (fall_ev & fall_q);
        prev_d  = deb_q;
    end

    // State registers, synchronous active-high reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            out_q    <= '0;
            dir_q    <= '0;
            ien_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            pend_q   <= '0;
            dbn_q    <= '0;
            cnt_q    <= '0;
            sync_q   <= '0;
            sample_q <= '0;
            deb_q    <= '0;
            prev_q   <= '0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            out_q    <= out_d;
            dir_q    <= dir_d;
            ien_q    <= ien_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            pend_q   <= pend_d;
            dbn_q    <= dbn_d;
            cnt_q    <= cnt_d;
            sync_q   <= sync_d;
            sample_q <= sample_d;
            deb_q    <= deb_d;
            prev_q   <= prev_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign gpio_o     = out_q;
    assign gpio_dir_o = dir_q;
    assign irq_o      = |(pend_q & ien_q);

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Bench for wb_gpio_irq (GPIO_WIDTH=8, SYNC_STAGES=2): register table,
// timing corner sequences, and randomized pad/W1C traffic vs a pin-level model.
module tb_wb_gpio_irq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  adr, dati, dato;
    logic [3:0]   sel;
    logic         we, cyc, stb, ack, irq;
    logic [W-1:0] gi, go, gd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_gpio_irq #(.GPIO_WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_WIDTH(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dati),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_dat_o(dato), .wb_ack_o(ack), .gpio_i(gi), .gpio_o(go),
        .gpio_dir_o(gd), .irq_o(irq)
    );

    typedef struct {
        logic [2:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output logic [31:0] r);
        logic got;
        got  = 1'b0;
        cyc  = 1'b1; stb = 1'b1; we = w;
        adr  = {27'd0, a, 2'b00}; dati = d; sel = s;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        r   = dato;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: no ack for word %0d, got ack=0 want 1", a);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(a, d, s, 1'b1, dummy);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] r);
        xfer(a, 32'd0, 4'hF, 1'b0, r);
    endtask

    initial begin
        logic [31:0] r, d;
        logic [3:0]  s;
        logic [7:0]  pad_m, pend_m, rise_m, fall_m, ien_m, out_m, nxt;
        int          nd;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dati = '0; sel = '0; gi = '0;

        // reset state
        step(3);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dato, 32'd0);
        chk("rst_gpio_o", {24'd0, go}, 32'd0);
        chk("rst_dir", {24'd0, gd}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        step(1);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), r);
            chk($sformatf("rst_rd%0d", a), r, 32'd0);
        end

        // register write/readback table
        tbl[0]  = '{3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0000_00FF};
        tbl[1]  = '{3'd2, 32'h0000_AA00, 4'h2, 32'h0000_0000};
        tbl[2]  = '{3'd2, 32'h0000_00A5, 4'h1, 32'h0000_00A5};
        tbl[3]  = '{3'd2, 32'h0000_005A, 4'h0, 32'h0000_00A5};
        tbl[4]  = '{3'd3, 32'h1234_5678, 4'hF, 32'h0000_0078};
        tbl[5]  = '{3'd4, 32'hFFFF_FF00, 4'hF, 32'h0000_0000};
        tbl[6]  = '{3'd5, 32'h0000_003C, 4'h1, 32'h0000_003C};
        tbl[7]  = '{3'd7, 32'h1234_5678, 4'h3, 32'h0000_5678};
        tbl[8]  = '{3'd7, 32'h0000_00AB, 4'h1, 32'h0000_56AB};
        tbl[9]  = '{3'd0, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        tbl[10] = '{3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        tbl[11] = '{3'd7, 32'h0000_0000, 4'hF, 32'h0000_0000};
        tbl[12] = '{3'd3, 32'h0000_0000, 4'hF, 32'h0000_0000};
        tbl[13] = '{3'd5, 32'h0000_0000, 4'hF, 32'h0000_0000};
        tbl[14] = '{3'd1, 32'h0000_0000, 4'hF, 32'h0000_0000};
        tbl[15] = '{3'd2, 32'h0000_0000, 4'hF, 32'h0000_0000};
        for (int i = 0; i < 16; i++) begin
            wr(tbl[i].adr, tbl[i].dat, tbl[i].sel);
            rd(tbl[i].adr, r);
            chk($sformatf("tbl%0d", i), r, tbl[i].exp);
            if (i == 3) begin
                chk("pins_out", {24'd0, go}, 32'h0000_00FF);
                chk("pins_dir", {24'd0, gd}, 32'h0000_00A5);
            end
        end
        chk("pins_out_clr", {24'd0, go}, 32'd0);

        // held strobe on a read acks every other cycle
        step(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk($sformatf("held_ack_c%0d", i), {31'd0, ack}, {31'd0, i[0]});
        end
        cyc = 1'b0; stb = 1'b0;

        // rising edge on pin 0 reaches PENDING/irq on the 4th edge
        wr(3'd4, 32'h01, 4'hF);
        wr(3'd3, 32'h01, 4'hF);
        gi[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("edge_irq_e%0d", k), {31'd0, irq}, {31'd0, k == 4});
        end
        rd(3'd6, r);
        chk("edge_pend", r, 32'h01);
        wr(3'd6, 32'h01, 4'hF);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        rd(3'd6, r);
        chk("w1c_pend", r, 32'h00);

        // fall on pin 3 sets PENDING[3] on the same edge a W1C clears it
        gi[3] = 1'b1;
        step(6);
        wr(3'd5, 32'h08, 4'hF);
        gi[3] = 1'b0;
        step(3);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h18; dati = 32'h08; sel = 4'hF;
        step(1);
        chk("simul_ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rd(3'd6, r);
        chk("simul_pend", r, 32'h08);
        wr(3'd6, 32'h08, 4'hF);
        rd(3'd6, r);
        chk("simul_clr", r, 32'h00);
        wr(3'd5, 32'h00, 4'hF);

        // masked pending bit raises irq once enabled
        wr(3'd3, 32'h00, 4'hF);
        wr(3'd4, 32'h04, 4'hF);
        gi[2] = 1'b1;
        step(6);
        chk("mask_irq_off", {31'd0, irq}, 32'd0);
        rd(3'd6, r);
        chk("mask_pend", r, 32'h04);
        wr(3'd3, 32'h04, 4'hF);
        chk("mask_irq_on", {31'd0, irq}, 32'd1);
        wr(3'd6, 32'hFF, 4'hF);
        wr(3'd3, 32'h00, 4'hF);

        // debounce N=4: short glitch rejected, long level accepted in 12 edges
        wr(3'd4, 32'h02, 4'hF);
        wr(3'd7, 32'h04, 4'hF);
        gi[1] = 1'b1;
        step(3);
        gi[1] = 1'b0;
        step(30);
        rd(3'd0, r);
        chk("deb_glitch_in", r, 32'h05);
        rd(3'd6, r);
        chk("deb_glitch_pend", r, 32'h00);
        gi[1] = 1'b1;
        step(12);
        rd(3'd0, r);
        chk("deb_long_in", r, 32'h07);
        step(6);
        gi[1] = 1'b0;
        step(30);
        rd(3'd6, r);
        chk("deb_long_pend", r, 32'h02);
        rd(3'd0, r);
        chk("deb_long_fall_in", r, 32'h05);
        wr(3'd6, 32'hFF, 4'hF);
        wr(3'd4, 32'h00, 4'hF);

        // randomized pads, edge enables, W1C and OUT writes vs pin-level model
        pad_m = gi; pend_m = 8'h00; rise_m = 8'h00; fall_m = 8'h00;
        ien_m = 8'h00; out_m = 8'h00;
        nd = int'($urandom_range(0, 3));
        wr(3'd7, 32'(nd), 4'hF);
        for (int rnd = 0; rnd < 40; rnd++) begin
            if (rnd % 5 == 0) begin
                rise_m = 8'($urandom); fall_m = 8'($urandom); ien_m = 8'($urandom);
                wr(3'd4, {24'd0, rise_m}, 4'hF);
                wr(3'd5, {24'd0, fall_m}, 4'hF);
                wr(3'd3, {24'd0, ien_m}, 4'hF);
            end
            nxt    = 8'($urandom);
            pend_m = pend_m | (nxt & ~pad_m & rise_m) | (~nxt & pad_m & fall_m);
            pad_m  = nxt;
            gi     = nxt;
            step(2 * (nd + 1) + 6);
            chk($sformatf("rnd%0d_irq", rnd), {31'd0, irq}, {31'd0, |(pend_m & ien_m)});
            rd(3'd0, r);
            chk($sformatf("rnd%0d_in", rnd), r, {24'd0, pad_m});
            rd(3'd6, r);
            chk($sformatf("rnd%0d_pend", rnd), r, {24'd0, pend_m});
            d = $urandom; s = 4'($urandom);
            if (s[0]) pend_m = pend_m & ~d[7:0];
            wr(3'd6, d, s);
            d = $urandom; s = 4'($urandom);
            if (s[0]) out_m = d[7:0];
            wr(3'd1, d, s);
            chk($sformatf("rnd%0d_out", rnd), {24'd0, go}, {24'd0, out_m});
        end
        rd(3'd6, r);
        chk("rnd_final_pend", r, {24'd0, pend_m});

        // reset during a write request: no ack, no commit, no spurious pending
        step(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; dati = 32'h55; sel = 4'hF;
        rst = 1'b1;
        step(1);
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_out", {24'd0, go}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step(1);
        chk("postrst_ack", {31'd0, ack}, 32'd0);
        step(5);
        rd(3'd1, r);
        chk("postrst_out", r, 32'd0);
        rd(3'd6, r);
        chk("postrst_pend", r, 32'd0);
        rd(3'd0, r);
        chk("postrst_in", r, {24'd0, pad_m});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
